// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder.
//   state_e     : controller states (idle, latency wait, response pending)
//   WORD_W/BE_W : data word and byte-enable widths
//   word_index  : byte address -> word index
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with byte-enable write and registered read.
//   clk   : rising-edge clock
//   en    : access strobe; nothing happens when low
//   we    : 1 = write, 0 = read
//   addr  : word index
//   be    : byte enables for writes (bit i -> bits 8i+7:8i)
//   wdata : write data
//   rdata : read data, registered; holds until the next read
// Contents and rdata are not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(BE_W); i++) begin
          if (be[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one word request at a time over a valid/ready request
// channel, response after a fixed LATENCY over a valid/ready response channel.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake
//   req_wr               : 1 = write, 0 = read
//   req_addr             : byte address
//   req_wdata, req_be    : write data and byte enables
//   resp_valid/resp_ready: response handshake
//   resp_rdata           : read data (0 for writes and errors)
//   resp_err             : misaligned or out-of-range request
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_ok_q, rd_ok_d;
  logic       err_q, err_d;

  logic [29:0]       idx;
  logic              addr_err;
  logic              accept;
  logic              resp_hs;
  logic [WORD_W-1:0] arr_rdata;

  assign idx      = word_index(req_addr);
  // No aliasing: any word index past the array is an error.
  assign addr_err = (req_addr[1:0] != 2'b00) || ({2'b00, idx} >= 32'(DEPTH));
  assign accept   = req_valid && req_ready;
  assign resp_hs  = resp_valid && resp_ready;

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = err_q;
  // The array read register is only touched at acceptance, so it holds the
  // read word stable for the whole response phase.
  assign resp_rdata = rd_ok_q ? arr_rdata : '0;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (clk),
    .en    (accept && !addr_err),
    .we    (req_wr),
    .addr  (idx[AW-1:0]),
    .be    (req_be),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_ok_d = rd_ok_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rd_ok_d = !req_wr && !addr_err;
          err_d   = addr_err;
          if (LATENCY <= 1) begin
            state_d = StResp;
            cnt_d   = '0;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_hs) begin
          state_d = StIdle;
          rd_ok_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_ok_q <= rd_ok_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total;
  int bad;

  mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Issues one request, checks the latency and response
  // fields; if resp_ready is high, also checks the handshake returns to idle.
  // Returns at a negedge.
  task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request fields to confirm they were captured.
    req_valid = 1'b0;
    req_wr    = ~wr;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 16);
    chk({tag, ".latency"}, n, LATENCY);
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    if (resp_ready) begin
      @(negedge clk);
      chk({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, ".idle_valid"}, {31'd0, resp_valid}, 32'd0);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.err", {31'd0, resp_err}, 32'd0);

    // Full write and read back.
    xact("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact("rd_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Partial write on byte 0 only.
    xact("wr_part", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
    xact("rd_part", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

    // Errors: misaligned, out of range, error write must not touch memory.
    xact("rd_mis", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
    xact("rd_oor", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
    xact("wr_mis", 1'b1, 32'h11, 32'h11111111, 4'hF, 32'h0, 1'b1);
    xact("rd_after_err", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

    // Zero byte enables leave the word alone.
    xact("wr_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    xact("rd_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

    // Last valid word.
    xact("wr_last", 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xact("rd_last", 1'b0, 32'hFFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    // Backpressure: response held for 5 cycles.
    resp_ready = 1'b0;
    xact("bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid", {31'd0, resp_valid}, 32'd1);
      chk("bp.rdata", resp_rdata, 32'hDEADBEAA);
      chk("bp.err", {31'd0, resp_err}, 32'd0);
      chk("bp.req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp.after_ready", {31'd0, req_ready}, 32'd1);
    chk("bp.after_valid", {31'd0, resp_valid}, 32'd0);

    // Reset while waiting: response dropped, write kept.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    chk("rstw.req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstw.in_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw.req_ready_after", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw.no_resp", {31'd0, resp_valid}, 32'd0);
    end
    xact("rstw.rd", 1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
